// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader: controller state encoding and
// output buffer sizing.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-side and downstream handshake signals of the FIFO reader.
// master: the reader block; slave: the FIFO/consumer environment.
interface fifo_reader_if #(
  parameter int WIDTH = 8
);

  logic             empty;
  logic             read;
  logic [WIDTH-1:0] DATA_OUT;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  empty,
    input  DATA_OUT,
    input  m_ready,
    output read,
    output m_valid,
    output m_data
  );

  modport slave (
    output empty,
    output DATA_OUT,
    output m_ready,
    input  read,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry in-order output buffer: captures returning FIFO words and
// presents the oldest one on a valid/ready port.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture_valid,
  input  logic [WIDTH-1:0] capture_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [OCC_W-1:0] count;
  logic             xfer;

  assign valid     = (count != '0);
  assign data      = head;
  assign occupancy = count;
  assign xfer      = valid & ready;

  // The issuing side's credit check guarantees no capture arrives while full
  // unless the head is leaving in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({capture_valid, xfer})
        2'b10: begin
          if (count == '0) head <= capture_data;
          else             tail <= capture_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= capture_data;
          end else begin
            head <= tail;
            tail <= capture_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// FIFO reader: pops a 1-cycle-latency FIFO under credit control and streams
// the words downstream through a 2-entry buffer, counting deliveries.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  fifo_reader_if.master    bus,
  output logic             busy,
  output logic [CNT_W-1:0] pop_count
);

  state_t           state;
  state_t           state_nxt;
  logic             vld_p1;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W:0]   pending;
  logic             credit_ok;
  logic             xfer;

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clock        (clock),
    .reset        (reset),
    .capture_valid(vld_p1),
    .capture_data (bus.DATA_OUT),
    .ready        (bus.m_ready),
    .valid        (bus.m_valid),
    .data         (bus.m_data),
    .occupancy    (occupancy)
  );

  assign xfer = bus.m_valid & bus.m_ready;

  // A word leaving this cycle frees its slot for the read issued now, which
  // keeps a full-rate stream at one word per cycle.
  assign pending   = {1'b0, occupancy} + {{OCC_W{1'b0}}, vld_p1}
                   - {{OCC_W{1'b0}}, xfer};
  assign credit_ok = (pending < (OCC_W + 1)'(BUF_DEPTH));

  always_comb begin
    state_nxt = state;
    bus.read  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable) state_nxt = STOP;
        bus.read = enable & ~bus.empty & credit_ok;
      end
      STOP: begin
        if (enable)                               state_nxt = RUN;
        else if (!vld_p1 && (occupancy == '0))    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: a read accepted this edge returns its word on DATA_OUT next cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      pop_count <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= bus.read;
      if (xfer) pop_count <= pop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized bench for fifo_reader: a queue-based FIFO and scoreboard predict
// delivered data, m_valid, pop_count and the read/outstanding-word limits.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] pop_count;

  fifo_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_reader #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .pop_count(pop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               inflight_m;
  int               pc;
  int               rd_total, xf_total, cyc;
  bit               prev_stall;
  logic [WIDTH-1:0] prev_data;
  int               first_rd, first_xf, last_xf;
  logic [WIDTH-1:0] last_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic marks();
    first_rd = -1;
    first_xf = -1;
    last_xf  = -1;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step();
    bit               rd, xf;
    logic [WIDTH-1:0] w;
    w = '0;
    bus.empty = (fq.size() == 0);
    #1;
    if (bus.read) chk("read_vs_empty", bus.empty, 0);
    chk("outstanding", exp_q.size() <= 2, 1);
    chk("m_valid", bus.m_valid, (exp_q.size() - int'(inflight_m)) > 0);
    if (bus.m_valid && exp_q.size() > 0) chk("m_data", bus.m_data, exp_q[0]);
    if (prev_stall) chk("stall_hold", bus.m_data, prev_data);
    chk("pop_count", pop_count, pc & ((1 << CNT_W) - 1));
    rd = bus.read && !bus.empty;
    xf = bus.m_valid && bus.m_ready;
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    if (rd && first_rd < 0) first_rd = cyc;
    if (xf) begin
      if (first_xf < 0) first_xf = cyc;
      last_xf   = cyc;
      last_word = bus.m_data;
    end
    @(posedge clock);
    cyc++;
    if (xf) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      pc++;
      xf_total++;
    end
    inflight_m = rd;
    if (rd) begin
      w = fq.pop_front();
      exp_q.push_back(w);
      rd_total++;
    end
    @(negedge clock);
    bus.DATA_OUT = rd ? w : WIDTH'($urandom);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_read", bus.read, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pop_count", pop_count, 0);
    chk("rst_state", dut.state, IDLE);
    fq.delete();
    exp_q.delete();
    inflight_m = 0;
    pc         = 0;
    prev_stall = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int base_rd, base_xf;
    bit seen_stop;
    bus.empty    = 1'b1;
    bus.m_ready  = 1'b0;
    bus.DATA_OUT = '0;
    rd_total = 0; xf_total = 0; cyc = 0; pc = 0;
    inflight_m = 0; prev_stall = 0; prev_data = '0; last_word = '0;
    marks();
    @(negedge clock);
    do_reset();

    // Stream 0..8 at full rate
    for (int i = 0; i < 9; i++) fq.push_back(WIDTH'(i));
    enable = 1'b1;
    bus.m_ready = 1'b1;
    marks();
    base_xf = xf_total;
    for (int i = 0; i < 40 && (xf_total - base_xf) < 9; i++) step();
    chk("stream_done", xf_total - base_xf, 9);
    chk("stream_lat", first_xf - first_rd, 2);
    chk("stream_rate", last_xf - first_xf, 8);
    chk("stream_last", last_word, 8);
    chk("stream_cnt", pop_count, 9);

    // Backpressure
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(WIDTH'(8'hA0 + i));
    base_rd = rd_total;
    repeat (5) step();
    chk("bp_reads", (rd_total - base_rd) <= 2, 1);
    chk("bp_valid", bus.m_valid, 1);
    chk("bp_head", bus.m_data, 8'hA0);
    bus.m_ready = 1'b1;
    base_xf = xf_total;
    for (int i = 0; i < 20 && (xf_total - base_xf) < 4; i++) step();
    chk("bp_done", xf_total - base_xf, 4);
    chk("bp_last", last_word, 8'hA3);

    // Stop after first read
    do_reset();
    for (int i = 0; i < 3; i++) fq.push_back(WIDTH'(8'h10 + i));
    enable = 1'b1;
    bus.m_ready = 1'b1;
    base_rd = rd_total;
    base_xf = xf_total;
    for (int i = 0; i < 10 && rd_total == base_rd; i++) step();
    chk("stop_first_read", rd_total - base_rd, 1);
    enable = 1'b0;
    chk("stop_run", dut.state, RUN);
    seen_stop = 0;
    base_rd = rd_total;
    for (int i = 0; i < 20 && !(seen_stop && dut.state == IDLE); i++) begin
      if (dut.state == STOP) seen_stop = 1;
      step();
    end
    repeat (2) step();
    chk("stop_seen", seen_stop, 1);
    chk("stop_idle", dut.state, IDLE);
    chk("stop_no_reads", rd_total - base_rd, 0);
    chk("stop_delivered", xf_total - base_xf, 1);
    chk("stop_word", last_word, 8'h10);
    chk("stop_busy", busy, 0);
    fq.delete();

    // Underflow with a single word
    do_reset();
    fq.push_back(8'h3C);
    enable = 1'b1;
    bus.m_ready = 1'b1;
    base_rd = rd_total;
    base_xf = xf_total;
    repeat (10) step();
    chk("uf_reads", rd_total - base_rd, 1);
    chk("uf_xfers", xf_total - base_xf, 1);
    chk("uf_valid", bus.m_valid, 0);

    // Reset while two words are buffered
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(WIDTH'($urandom));
    for (int i = 0; i < 10 && (exp_q.size() - int'(inflight_m)) != 2; i++) step();
    chk("mid_fill", exp_q.size() - int'(inflight_m), 2);
    do_reset();
    fq.push_back(8'h55);
    bus.m_ready = 1'b1;
    base_xf = xf_total;
    for (int i = 0; i < 10 && xf_total == base_xf; i++) step();
    chk("mid_done", xf_total - base_xf, 1);
    chk("mid_word", last_word, 8'h55);

    // Counter wrap with random backpressure
    do_reset();
    for (int i = 0; i < 17; i++) fq.push_back(WIDTH'($urandom));
    enable = 1'b1;
    base_xf = xf_total;
    for (int i = 0; i < 200 && (xf_total - base_xf) < 17; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("wrap_done", xf_total - base_xf, 17);
    chk("wrap_cnt", pop_count, 1);

    // Random soak
    for (int i = 0; i < 400; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) fq.push_back(WIDTH'($urandom));
      step();
    end
    enable = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 200 && (fq.size() != 0 || exp_q.size() != 0); i++) step();
    chk("soak_drain", fq.size() + exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits.
REQ-002 Parameter CNT_W, default 16: width of the pop counter.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port enable, input, 1: high permits new FIFO reads.
REQ-006 Port empty, input, 1: FIFO empty flag, sampled at the rising edge.
REQ-007 Port read, output, 1: FIFO pop strobe.
REQ-008 Port DATA_OUT, input, WIDTH: FIFO read data, valid the cycle after an accepted read.
REQ-009 Port m_valid, output, 1: downstream data valid.
REQ-010 Port m_data, output, WIDTH: downstream data.
REQ-011 Port m_ready, input, 1: downstream accept.
REQ-012 Port busy, output, 1: high whenever the state is not IDLE.
REQ-013 Port pop_count, output, CNT_W: total words delivered downstream.

Function
REQ-014 A read is accepted by the FIFO when read=1 and empty=0 at the same rising edge; DATA_OUT is valid in the next cycle (1-cycle latency).
REQ-015 read shall be asserted only when empty=0, the state is RUN, and (buffered words + in-flight reads) < 2.
REQ-016 The block shall hold a 2-entry output buffer; every returning DATA_OUT word shall be captured, with no loss or duplication.
REQ-017 m_valid=1 whenever the buffer is non-empty; m_data shall be the oldest buffered word.
REQ-018 m_data shall remain stable while m_valid=1 and m_ready=0.
REQ-019 A transfer occurs when m_valid=1 and m_ready=1; the buffer then advances one entry.
REQ-020 A capture and a transfer in the same cycle shall keep the occupancy unchanged and preserve order.
REQ-021 Throughput: with empty=0, enable=1, and m_ready=1 held, one word shall be delivered per cycle after a 2-cycle startup latency (read asserted, data captured, m_valid=1).
REQ-022 pop_count shall increment by 1 per transfer and wrap from 2^CNT_W-1 to 0.
REQ-023 The state machine has three states:
- IDLE to RUN when enable=1.
- RUN to STOP when enable=0.
- STOP to IDLE when no read is in flight and the buffer is empty.
- STOP to RUN when enable=1.
REQ-024 In STOP, no new reads shall be issued; in-flight data shall still be captured and delivered.
REQ-025 If empty rises while the block is in RUN, read shall drop in the same cycle (combinational on empty) and no underflow shall occur.

Reset
REQ-026 While reset=0, the block shall force:
- read=0, m_valid=0, m_data=0, busy=0, pop_count=0
- buffer occupancy and in-flight count to 0
- state to IDLE
REQ-027 A reset asserted mid-operation shall discard buffered and in-flight data without delivering it.
REQ-028 The first read after reset release shall occur no earlier than the first rising edge with reset=1, enable=1, and empty=0.

Structure
REQ-029 Shared package fifo_pkg shall hold the state encoding (IDLE=2'd0, RUN=2'd1, STOP=2'd2) and the buffer depth constant (2).
REQ-030 The 2-entry output buffer shall be a sub-module named skid_buf2, with ports: capture valid/data in, ready/valid/data out, and occupancy out.
REQ-031 The fifo_reader top level shall contain the state machine, the read-issue credit logic, the in-flight flag, and pop_count.

Verification
REQ-032 Stream: after reset, the FIFO model is preloaded with 0..8, enable=1, m_ready=1. Required: m_data delivers 0..8 in order, one word per cycle starting in cycle 2; pop_count=9; read never asserted while empty=1.
REQ-033 Backpressure: with 4 words 0xA0..0xA3 in the FIFO, m_ready=0 for 5 cycles, then 1. Required: at most 2 reads before the stall; m_data holds 0xA0 stable; all 4 words delivered in order afterwards.
REQ-034 Stop: enable is dropped one cycle after the first read. Required: the state passes RUN, then STOP, then IDLE; the in-flight word is delivered; no further reads; busy=0 once in IDLE.
REQ-035 Underflow: the FIFO holds 1 word. Required: exactly one read; empty=1 blocks further reads; m_valid stays 0 after the single transfer.
REQ-036 Reset mid-run: reset=0 is asserted while 2 words are buffered. Required: all outputs immediately 0 and state IDLE; after release with the FIFO holding 0x55, the next delivered word is 0x55.
REQ-037 Wrap: with CNT_W=4, deliver 17 words. Required: pop_count=1.
